// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: received bytes are queued in a FIFO and retransmitted under CTS_N flow control.
// Define ECHO_UPPERCASE_EN to fold ASCII 'a'..'z' to upper case as bytes are stored.
module rxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104
) (
  input  logic       i_clk,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data
);
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state;
  logic [2:0]  sync;
  logic [23:0] cnt;
  logic [3:0]  bitn;
  logic [7:0]  sh;

  assign o_data = sh;

  // Start is a falling edge, so an all-zero power-up synchronizer never fakes a frame.
  always_ff @(posedge i_clk) begin
    sync <= {sync[1:0], i_uart_rx};
    o_wr <= 1'b0;
    case (state)
      RX_IDLE: begin
        if (sync[2] && !sync[1]) begin
          state <= RX_DATA;
          cnt   <= CLOCKS_PER_BAUD + (CLOCKS_PER_BAUD >> 1) - 24'd1;
          bitn  <= 4'd0;
        end
      end
      RX_DATA: begin
        if (cnt != 24'd0) begin
          cnt <= cnt - 24'd1;
        end else begin
          sh   <= {sync[1], sh[7:1]};
          bitn <= bitn + 4'd1;
          cnt  <= CLOCKS_PER_BAUD - 24'd1;
          if (bitn == 4'd7) state <= RX_STOP;
        end
      end
      default: begin
        if (cnt != 24'd0) begin
          cnt <= cnt - 24'd1;
        end else begin
          o_wr  <= sync[1];
          state <= RX_IDLE;
        end
      end
    endcase
  end
endmodule

module txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104
) (
  input  logic       i_clk,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_uart_tx,
  output logic       o_busy
);
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t   state;
  logic [23:0] cnt;
  logic [3:0]  bitn;
  logic [9:0]  sh;

  assign o_busy    = (state == TX_SEND);
  assign o_uart_tx = (state == TX_IDLE) | sh[0];

  always_ff @(posedge i_clk) begin
    case (state)
      TX_IDLE: begin
        if (i_wr) begin
          sh    <= {1'b1, i_data, 1'b0};
          bitn  <= 4'd9;
          cnt   <= CLOCKS_PER_BAUD - 24'd1;
          state <= TX_SEND;
        end
      end
      default: begin
        if (cnt != 24'd0) begin
          cnt <= cnt - 24'd1;
        end else if (bitn != 4'd0) begin
          sh   <= {1'b1, sh[9:1]};
          bitn <= bitn - 4'd1;
          cnt  <= CLOCKS_PER_BAUD - 24'd1;
        end else begin
          state <= TX_IDLE;
        end
      end
    endcase
  end
endmodule

module uart_echo_fifo #(
  parameter int CLOCK_RATE_HZ = 12_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int LGFIFO        = 4
) (
  input  logic            CLK,
  input  logic            BTN_N,
  input  logic            RX,
  output logic            TX,
  input  logic            CTS_N,
  output logic [LGFIFO:0] o_fill,
  output logic            o_overflow
);
  localparam logic [23:0] CLOCKS_PER_BAUD = 24'(CLOCK_RATE_HZ / BAUD_RATE);
  localparam int DEPTH  = 2 ** LGFIFO;
  localparam int DATA_W = 8;

  logic              rx_wr;
  logic [DATA_W-1:0] rx_data;
  logic              tx_stb;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_data;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LGFIFO:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, fill_nxt;
  logic              full, push, pop;

  rxuart #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_rx (
    .i_clk(CLK), .i_uart_rx(RX), .o_wr(rx_wr), .o_data(rx_data)
  );

  txuart #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_tx (
    .i_clk(CLK), .i_wr(tx_stb), .i_data(tx_data), .o_uart_tx(TX), .o_busy(tx_busy)
  );

  function automatic logic [DATA_W-1:0] fold_case(input logic [DATA_W-1:0] b);
`ifdef ECHO_UPPERCASE_EN
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
    return b;
`endif
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a coincident push.
  assign full     = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                    (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
  assign pop      = tx_stb && !tx_busy;
  assign push     = rx_wr && (!full || pop);
  assign wr_nxt   = wr_ptr + (LGFIFO+1)'(push);
  assign rd_nxt   = rd_ptr + (LGFIFO+1)'(pop);
  assign fill_nxt = wr_nxt - rd_nxt;
  assign tx_data  = mem[rd_ptr[LGFIFO-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[LGFIFO-1:0]] <= fold_case(rx_data);
  end

  always_ff @(posedge CLK) begin
    if (!BTN_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_fill     <= '0;
      o_overflow <= 1'b0;
      tx_stb     <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      o_fill <= fill_nxt;
      if (rx_wr && !push) o_overflow <= 1'b1;
      tx_stb <= (fill_nxt != '0) && !CTS_N;
    end
  end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo, run at 16 clocks per baud to keep frames short.
module tb_uart_echo_fifo;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       BTN_N = 1'b0;
  logic       RX = 1'b1;
  logic       TX;
  logic       CTS_N = 1'b0;
  logic [4:0] o_fill;
  logic       o_overflow;

  int         checks = 0;
  int         errors = 0;
  int         frame_err = 0;
  int         lat = 0;
  logic [7:0] got_q[$];
  logic [7:0] mon_b;
  logic [7:0] exp_lc;

  always #5 CLK = ~CLK;

  uart_echo_fifo #(.CLOCK_RATE_HZ(1_600_000), .BAUD_RATE(100_000), .LGFIFO(4)) dut (
    .CLK(CLK), .BTN_N(BTN_N), .RX(RX), .TX(TX), .CTS_N(CTS_N),
    .o_fill(o_fill), .o_overflow(o_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check(tag, got_q.size(), n);
  endtask

  task automatic wait_tx_low(input int budget, input string tag);
    int t = 0;
    while (TX && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check(tag, TX, 1'b0);
  endtask

  // Line monitor: decodes every 8N1 frame seen on TX into got_q.
  initial begin
    forever begin
      @(negedge TX);
      repeat (CPB / 2) @(negedge CLK);
      if (TX !== 1'b0) begin
        frame_err++;
      end else begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          mon_b[i] = TX;
        end
        repeat (CPB) @(negedge CLK);
        if (TX !== 1'b1) frame_err++;
        else got_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_fill", o_fill, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_tx_idle", TX, 1);
    check("rst_tx_stb", dut.tx_stb, 0);
    BTN_N = 1'b1;
    @(negedge CLK);

    // Single byte: fill rises one cycle after o_wr and falls at the transfer.
    fork send_byte(8'h41); join_none
    while (!dut.rx_wr && lat < 20 * CPB) begin
      @(negedge CLK);
      lat++;
    end
    check("t1_rx_wr", dut.rx_wr, 1);
    check("t1_fill_at_wr", o_fill, 0);
    @(negedge CLK);
    check("t1_fill_after_wr", o_fill, 1);
    @(negedge CLK);
    check("t1_fill_after_pop", o_fill, 0);
    wait_frames(1, 2 * FRAME, "t1_frames");
    check("t1_byte", got_q[0], 8'h41);

    // Overflow with CTS held off.
    got_q.delete();
    CTS_N = 1'b1;
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    repeat (4) @(negedge CLK);
    check("t2_fill_full", o_fill, 16);
    check("t2_overflow", o_overflow, 1);
    check("t2_tx_idle", TX, 1);
    check("t2_no_frames", got_q.size(), 0);
    CTS_N = 1'b0;
    wait_frames(16, 16 * (FRAME + 2) + 100, "t2_frames");
    for (int i = 0; i < 16; i++) check($sformatf("t2_byte%0d", i), got_q[i], 32'(i));
    repeat (2 * FRAME) @(negedge CLK);
    check("t2_no_extra", got_q.size(), 16);
    check("t2_fill_end", o_fill, 0);

    // Push coinciding with a transfer while full.
    BTN_N = 1'b0;
    @(negedge CLK);
    BTN_N = 1'b1;
    check("t3_overflow_cleared", o_overflow, 0);
    got_q.delete();
    CTS_N = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    repeat (4) @(negedge CLK);
    check("t3_fill_full", o_fill, 16);
    @(negedge CLK);
    fork send_byte(8'h30); join_none
    repeat (lat - 1) @(negedge CLK);
    CTS_N = 1'b0;
    @(negedge CLK);
    check("t3_coincide_wr", dut.rx_wr, 1);
    check("t3_coincide_pop", dut.tx_stb && !dut.tx_busy, 1);
    @(negedge CLK);
    check("t3_fill_stays", o_fill, 16);
    check("t3_no_overflow", o_overflow, 0);
    wait_frames(17, 17 * (FRAME + 2) + 200, "t3_frames");
    check("t3_first", got_q[0], 8'h20);
    check("t3_sixteenth", got_q[15], 8'h2F);
    check("t3_last", got_q[16], 8'h30);
    check("t3_fill_end", o_fill, 0);

    // Mid-burst reset.
    got_q.delete();
    CTS_N = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    repeat (4) @(negedge CLK);
    check("t4_fill5", o_fill, 5);
    CTS_N = 1'b0;
    wait_tx_low(4 * CPB, "t4_start");
    repeat (3 * CPB) @(negedge CLK);
    BTN_N = 1'b0;
    @(negedge CLK);
    check("t4_rst_fill", o_fill, 0);
    check("t4_rst_overflow", o_overflow, 0);
    check("t4_rst_tx_stb", dut.tx_stb, 0);
    BTN_N = 1'b1;
    repeat (2 * FRAME) @(negedge CLK);
    check("t4_one_frame", got_q.size(), 1);
    check("t4_inflight_byte", got_q[0], 8'h01);
    send_byte(8'h55);
    wait_frames(2, 2 * FRAME, "t4_after_frames");
    check("t4_echo55", got_q[1], 8'h55);

    // Case folding option.
    got_q.delete();
    send_byte(8'h61);
    send_byte(8'h5B);
    wait_frames(2, 3 * FRAME, "t5_frames");
`ifdef ECHO_UPPERCASE_EN
    exp_lc = 8'h41;
`else
    exp_lc = 8'h61;
`endif
    check("t5_lower", got_q[0], exp_lc);
    check("t5_bracket", got_q[1], 8'h5B);

    // CTS raised mid-frame.
    got_q.delete();
    CTS_N = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (4) @(negedge CLK);
    check("t6_fill3", o_fill, 3);
    CTS_N = 1'b0;
    wait_tx_low(4 * CPB, "t6_start");
    CTS_N = 1'b1;
    @(negedge CLK);
    check("t6_fill2", o_fill, 2);
    repeat (3 * FRAME) @(negedge CLK);
    check("t6_held_count", got_q.size(), 1);
    check("t6_held_byte", got_q[0], 8'h11);
    check("t6_held_fill", o_fill, 2);
    check("t6_held_tx", TX, 1);
    CTS_N = 1'b0;
    wait_frames(3, 3 * FRAME, "t6_frames");
    check("t6_second", got_q[1], 8'h22);
    check("t6_third", got_q[2], 8'h33);
    repeat (CPB) @(negedge CLK);
    check("t6_fill_end", o_fill, 0);

    check("framing", frame_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
